// File: rtl/nine_segment_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nine_segment_pattern_sequencer
// Brief    : Frame store with timed one-shot / looping playback of 9-bit
//            segment frames for the nine_segment_to_six_pin converter.
// Revision : 1.0 - initial release
// ============================================================================
module nine_segment_pattern_sequencer #(
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [8:0]                  load_data,
    input  logic                        clear,
    input  logic                        start,
    input  logic                        halt,
    input  logic                        loop,
    input  logic [PERIOD_W-1:0]         frame_period,
    output logic [8:0]                  segments,
    output logic [$clog2(DEPTH)-1:0]    frame_idx,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        playing,
    output logic                        done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    logic [0:0]          r_state;
    logic [8:0]          r_mem [DEPTH];
    logic [8:0]          r_segments;
    logic [IDX_W-1:0]    r_frame_idx;
    logic [CNT_W-1:0]    r_count;
    logic                r_playing;
    logic                r_done;
    logic                r_loop_q;
    logic [PERIOD_W-1:0] r_per_q;
    logic [PERIOD_W-1:0] r_timer;

    logic                w_load_ready;
    logic                w_load_fire;
    logic                w_last;
    logic [IDX_W-1:0]    w_next_idx;

    assign w_load_ready = (r_state == S_IDLE) && (r_count != CNT_W'(DEPTH)) && !start && !clear;
    assign w_load_fire  = load_valid && w_load_ready;
    assign w_last       = ({1'b0, r_frame_idx} == (r_count - CNT_W'(1)));
    assign w_next_idx   = r_frame_idx + IDX_W'(1);

    // Store contents need no reset; only count defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && w_load_fire) begin
            r_mem[r_count[IDX_W-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_segments  <= '0;
            r_frame_idx <= '0;
            r_count     <= '0;
            r_playing   <= 1'b0;
            r_done      <= 1'b0;
            r_loop_q    <= 1'b0;
            r_per_q     <= '0;
            r_timer     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_count <= '0;
                    end else if (start && (r_count != '0)) begin
                        r_state     <= S_PLAY;
                        r_loop_q    <= loop;
                        r_per_q     <= frame_period;
                        r_timer     <= frame_period;
                        r_frame_idx <= '0;
                        r_segments  <= r_mem[0];
                        r_playing   <= 1'b1;
                    end else if (w_load_fire) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_PLAY: begin
                    if (halt) begin
                        r_state     <= S_IDLE;
                        r_segments  <= '0;
                        r_frame_idx <= '0;
                        r_playing   <= 1'b0;
                    end else if (r_timer != '0) begin
                        r_timer <= r_timer - PERIOD_W'(1);
                    end else if (!w_last) begin
                        r_frame_idx <= w_next_idx;
                        r_segments  <= r_mem[w_next_idx];
                        r_timer     <= r_per_q;
                    end else if (r_loop_q) begin
                        r_frame_idx <= '0;
                        r_segments  <= r_mem[0];
                        r_timer     <= r_per_q;
                    end else begin
                        r_state     <= S_IDLE;
                        r_segments  <= '0;
                        r_frame_idx <= '0;
                        r_playing   <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign load_ready = w_load_ready;
    assign segments   = r_segments;
    assign frame_idx  = r_frame_idx;
    assign count      = r_count;
    assign playing    = r_playing;
    assign done       = r_done;

endmodule
`default_nettype wire
